// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the 4-byte RAM controller.
//   state_t   : controller FSM states (ST_IDLE, ST_SEL)
//   ADDR_W    : byte address width
//   BYTE_W    : data byte width
//   DEPTH     : number of stored bytes
//   CNT_W     : settle counter width (covers SETTLE values up to 15)
package ram_pkg;

    localparam int ADDR_W = 2;
    localparam int BYTE_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEL  = 1'b1
    } state_t;

    // Counter value loaded on read accept so that the capture lands SETTLE edges later.
    function automatic logic [CNT_W-1:0] settle_load(input int unsigned settle);
        return CNT_W'(settle - 32'd1);
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// ram_byte_array: 4 x 8-bit register array with synchronous write and
// synchronous active-high reset. The whole array is presented flattened so
// it can feed the byte inputs of the mux bank directly.
//   clk     : system clock
//   rst     : synchronous active-high reset, clears every byte
//   wr_en   : write strobe for this edge
//   wr_addr : byte to write
//   wr_data : value to write
//   bytes   : flattened array, byte k on bits [8k+7:8k]
module ram_byte_array
    import ram_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [BYTE_W-1:0]       wr_data,
    output logic [DEPTH*BYTE_W-1:0] bytes
);

    logic [BYTE_W-1:0]       mem_r [DEPTH];
    logic [DEPTH*BYTE_W-1:0] bytes_s;

    // Storage: clear on reset, otherwise update the addressed byte on a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Flatten the array; every bit comes straight from a storage flop.
    always_comb begin
        bytes_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bytes_s[k*BYTE_W +: BYTE_W] = mem_r[k];
        end
    end

    assign bytes = bytes_s;

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: control and storage stage of the 4-byte RAM.
// Accepts read/write requests over REQ/RDY. Writes update the byte array at
// the accepting edge and keep the controller idle. Reads latch the address on
// the mux selects, pull the active-low enables down, wait SETTLE cycles and
// capture the mux-bank output into RDATA with a one-cycle RVALID strobe.
//   CLK, RST     : clock, synchronous active-high reset
//   REQ, RDY     : request handshake (RDY high only while idle)
//   WE, ADDR     : 1 = write / 0 = read, byte address
//   WDATA        : write byte
//   BYTES        : stored array to the mux bank
//   MUXO         : mux-bank output (selected byte)
//   S1, S0       : mux select, equals the latched read address
//   E1, E2       : active-low mux enables, driven identically
//   RDATA, RVALID: captured read byte and its one-cycle strobe
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ,
    output logic                    RDY,
    input  logic                    WE,
    input  logic [ADDR_W-1:0]       ADDR,
    input  logic [BYTE_W-1:0]       WDATA,
    output logic [DEPTH*BYTE_W-1:0] BYTES,
    input  logic [BYTE_W-1:0]       MUXO,
    output logic                    S1,
    output logic                    S0,
    output logic                    E1,
    output logic                    E2,
    output logic [BYTE_W-1:0]       RDATA,
    output logic                    RVALID
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE);

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [ADDR_W-1:0]   sel_r, sel_s;
    logic                en_n_r, en_n_s;
    logic [BYTE_W-1:0]   rdata_r, rdata_s;
    logic                rvalid_r, rvalid_s;
    logic                wr_en_s;

    ram_byte_array u_array (
        .clk     (CLK),
        .rst     (RST),
        .wr_en   (wr_en_s),
        .wr_addr (ADDR),
        .wr_data (WDATA),
        .bytes   (BYTES)
    );

    // Next-state and next-output logic; RVALID is a strobe so it defaults low.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        sel_s    = sel_r;
        en_n_s   = en_n_r;
        rdata_s  = rdata_r;
        rvalid_s = 1'b0;
        wr_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (REQ) begin
                    if (WE) begin
                        // Write completes in the array at this edge; stay idle.
                        wr_en_s = 1'b1;
                    end else begin
                        sel_s   = ADDR;
                        en_n_s  = 1'b0;
                        cnt_s   = SETTLE_LOAD;
                        state_s = ST_SEL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (cnt_r == 4'd0) begin
                    // Select lines keep their value; only the enables release.
                    rdata_s  = MUXO;
                    rvalid_s = 1'b1;
                    en_n_s   = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                en_n_s  = 1'b1;
            end
        endcase
    end

    // Controller state and output registers; reset overrides every input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            sel_r    <= 2'b00;
            en_n_r   <= 1'b1;
            rdata_r  <= 8'h00;
            rvalid_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            sel_r    <= sel_s;
            en_n_r   <= en_n_s;
            rdata_r  <= rdata_s;
            rvalid_r <= rvalid_s;
        end
    end

    assign RDY    = (state_r == ST_IDLE);
    assign S1     = sel_r[1];
    assign S0     = sel_r[0];
    assign E1     = en_n_r;
    assign E2     = en_n_r;
    assign RDATA  = rdata_r;
    assign RVALID = rvalid_r;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: two controllers (SETTLE = 1 and SETTLE = 3) share clock and
// reset. Each has a behavioural mux bank returning the selected byte while
// both enables are low and 0x00 otherwise. Reads push their expected byte and
// expected RVALID cycle into a scoreboard; a negedge monitor pops and compares.
module tb_ram_ctrl;

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clk_s = 1'b0;
    logic        rst_s = 1'b1;
    logic        req_s   [2];
    logic        we_s    [2];
    logic [1:0]  addr_s  [2];
    logic [7:0]  wdata_s [2];
    logic        rdy_s   [2];
    logic [31:0] bytes_s [2];
    logic [7:0]  muxo_s  [2];
    logic        s1_s    [2];
    logic        s0_s    [2];
    logic        e1_s    [2];
    logic        e2_s    [2];
    logic [7:0]  rdata_s [2];
    logic        rvalid_s[2];

    exp_t        sb_q[$];
    logic [7:0]  exp_mem [2][4];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk_s = ~clk_s;

    always @(posedge clk_s) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_ctrl #(.SETTLE(g == 0 ? 1 : 3)) u_dut (
            .CLK    (clk_s),
            .RST    (rst_s),
            .REQ    (req_s[g]),
            .RDY    (rdy_s[g]),
            .WE     (we_s[g]),
            .ADDR   (addr_s[g]),
            .WDATA  (wdata_s[g]),
            .BYTES  (bytes_s[g]),
            .MUXO   (muxo_s[g]),
            .S1     (s1_s[g]),
            .S0     (s0_s[g]),
            .E1     (e1_s[g]),
            .E2     (e2_s[g]),
            .RDATA  (rdata_s[g]),
            .RVALID (rvalid_s[g])
        );
        assign muxo_s[g] = (!e1_s[g] && !e2_s[g]) ?
                           bytes_s[g][{s1_s[g], s0_s[g], 3'b000} +: 8] : 8'h00;
    end

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on instance i, holding REQ until RDY is seen.
    task automatic issue(input int i, input logic w, input logic [1:0] a,
                         input logic [7:0] d, output int waits, output logic rv_seen);
        exp_t e;
        req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d;
        waits = 0;
        while (!rdy_s[i] && waits < 50) begin
            @(posedge clk_s); #1;
            waits++;
        end
        if (!rdy_s[i]) begin
            n_checks++; n_errors++;
            $display("FAIL rdy_timeout: inst %0d got rdy=0 expected 1", i);
        end
        rv_seen = rvalid_s[i];
        if (!w) begin
            e.inst = i; e.data = exp_mem[i][a]; e.cyc = cyc + 1 + settle_of(i);
            sb_q.push_back(e);
        end
        @(posedge clk_s); #1;
        if (w) exp_mem[i][a] = d;
    endtask

    task automatic idle(input int i);
        req_s[i] = 1'b0; we_s[i] = 1'b0;
    endtask

    // Monitor: every RVALID must match the oldest scoreboard entry.
    always @(negedge clk_s) begin
        for (int i = 0; i < 2; i++) begin
            if (rvalid_s[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_rvalid: inst %0d rdata %h with no read pending", i, rdata_s[i]);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rv_inst", i, e.inst);
                    check("rdata", {24'h0, rdata_s[i]}, {24'h0, e.data});
                    check("rv_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int   w0, w1;
        logic rv;
        for (int i = 0; i < 2; i++) begin
            idle(i); addr_s[i] = 2'd0; wdata_s[i] = 8'h00;
            for (int k = 0; k < 4; k++) exp_mem[i][k] = 8'h00;
        end

        // Reset for two cycles, then check idle state on both instances.
        repeat (2) @(posedge clk_s);
        #1 rst_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rst_bytes", bytes_s[i], 32'h0);
            check("rst_rdata", {24'h0, rdata_s[i]}, 32'h0);
            check("rst_rvalid", {31'h0, rvalid_s[i]}, 32'h0);
            check("rst_e1", {31'h0, e1_s[i]}, 32'h1);
            check("rst_e2", {31'h0, e2_s[i]}, 32'h1);
            check("rst_rdy", {31'h0, rdy_s[i]}, 32'h1);
        end

        // Back-to-back writes on the SETTLE=1 instance.
        issue(0, 1'b1, 2'd0, 8'hA5, w0, rv);
        issue(0, 1'b1, 2'd3, 8'h3C, w1, rv);
        idle(0);
        check("wr_bytes", bytes_s[0], 32'h3C0000A5);
        check("wr_rdy_waits", w0 + w1, 0);
        check("wr_rdy_after", {31'h0, rdy_s[0]}, 32'h1);

        // SETTLE=1 read of address 3.
        issue(0, 1'b0, 2'd3, 8'h00, w0, rv);
        idle(0);
        check("rd1_sel", {30'h0, s1_s[0], s0_s[0]}, 32'h3);
        check("rd1_en", {30'h0, e1_s[0], e2_s[0]}, 32'h0);
        check("rd1_rdy_low", {31'h0, rdy_s[0]}, 32'h0);
        @(posedge clk_s); #1;
        check("rd1_rvalid", {31'h0, rvalid_s[0]}, 32'h1);
        check("rd1_en_off", {30'h0, e1_s[0], e2_s[0]}, 32'h3);
        check("rd1_sel_hold", {30'h0, s1_s[0], s0_s[0]}, 32'h3);
        check("rd1_rdy_back", {31'h0, rdy_s[0]}, 32'h1);
        @(posedge clk_s); #1;

        // SETTLE=3: two reads with REQ held high across both.
        issue(1, 1'b1, 2'd1, 8'h5A, w0, rv);
        issue(1, 1'b1, 2'd2, 8'hC3, w0, rv);
        idle(1);
        issue(1, 1'b0, 2'd1, 8'h00, w0, rv);
        check("rd3_rdy_low", {31'h0, rdy_s[1]}, 32'h0);
        issue(1, 1'b0, 2'd2, 8'h00, w1, rv);
        idle(1);
        check("rd3_rdy_waits", w1, 3);
        check("rd3_accept_in_rvalid", {31'h0, rv}, 32'h1);
        repeat (5) @(posedge clk_s);
        #1;

        // Read-after-write on the SETTLE=1 instance.
        issue(0, 1'b1, 2'd2, 8'h77, w0, rv);
        issue(0, 1'b0, 2'd2, 8'h00, w0, rv);
        idle(0);
        repeat (3) @(posedge clk_s);
        #1;

        // Reset one cycle after a SETTLE=3 read is accepted.
        issue(1, 1'b0, 2'd1, 8'h00, w0, rv);
        idle(1);
        rst_s = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) exp_mem[i][k] = 8'h00;
        @(posedge clk_s); #1;
        rst_s = 1'b0;
        check("mid_rst_e1", {31'h0, e1_s[1]}, 32'h1);
        check("mid_rst_e2", {31'h0, e2_s[1]}, 32'h1);
        check("mid_rst_rdy", {31'h0, rdy_s[1]}, 32'h1);
        check("mid_rst_bytes", bytes_s[1], 32'h0);
        check("mid_rst_bytes0", bytes_s[0], 32'h0);
        repeat (6) @(posedge clk_s);
        #1;

        // A read after reset returns the cleared byte.
        issue(1, 1'b0, 2'd2, 8'h00, w0, rv);
        idle(1);
        repeat (6) @(posedge clk_s);
        #1;
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
